blit_piece_reg: RTL and testbench



---
 rtl/blit_piece_reg.sv | 143 ++++++++++++++
 tb/tb_blit_piece_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/blit_piece_reg.sv
// blit_piece_reg: registered overlay of the falling tetromino onto the
// settled playfield, feeding the renderer.
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   async active-high, clears all outputs
//   no_piece           in   1 = no active piece, overlay suppressed
//   base_state         in   settled board (game_state_t)
//   active_piece_grid  in   4x4 occupancy window + 5-bit x/y anchors
//   out_state          out  registered composite board
//   collision          out  registered, only when BLIT_COLLISION_EN is defined
//
// Build option: define BLIT_COLLISION_EN to add the collision flag. The
// out_state path is identical with or without it.

package game_state_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  // screen[x][y]: x 0..9 left to right, y 0..19 bottom to top
  typedef struct packed {
    logic [BOARD_W-1:0][BOARD_H-1:0] screen;
    logic [15:0]                     score;
    logic [3:0]                      level;
    logic                            game_over;
  } game_state_t;
endpackage

package tetris_pkg;
  // piece[dx][dy]; board cell = (x + dx - 4, y + dy - 4)
  typedef struct packed {
    logic [3:0][3:0] piece;
    logic [4:0]      x;
    logic [4:0]      y;
  } active_piece_grid_t;
endpackage

// One piece-window cell: maps (DX,DY) onto the board and classifies it.
module blit_cell #(
  parameter int DX = 0,
  parameter int DY = 0
) (
  input  logic       occ,
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic       draw,   // occupied and on the board
  output logic       off,    // occupied but clipped
  output logic [3:0] cx,
  output logic [4:0] cy
);
  // 7-bit signed so anchors near 0 go negative instead of wrapping
  logic signed [6:0] bx, by;
  logic              on_board;

  assign bx = $signed({2'b00, x} + 7'(DX) - 7'd4);
  assign by = $signed({2'b00, y} + 7'(DY) - 7'd4);

  assign on_board = (bx >= 7'sd0) && (bx <= 7'sd9) &&
                    (by >= 7'sd0) && (by <= 7'sd19);

  assign draw = occ &  on_board;
  assign off  = occ & ~on_board;
  assign cx   = bx[3:0];
  assign cy   = by[4:0];
endmodule

module blit_piece_reg
  import game_state_pkg::*;
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               no_piece,
  input  game_state_t        base_state,
  input  active_piece_grid_t active_piece_grid,
  output game_state_t        out_state
`ifdef BLIT_COLLISION_EN
  ,
  output logic               collision
`endif
);
  localparam int NCELL = 16;

  logic [NCELL-1:0]       draw, off;
  logic [NCELL-1:0][3:0]  cx;
  logic [NCELL-1:0][4:0]  cy;

  // all 16 window cells mapped in parallel; index = dx*4 + dy
  for (genvar dx = 0; dx < 4; dx++) begin : g_dx
    for (genvar dy = 0; dy < 4; dy++) begin : g_dy
      blit_cell #(.DX(dx), .DY(dy)) u_cell (
        .occ  (active_piece_grid.piece[dx][dy]),
        .x    (active_piece_grid.x),
        .y    (active_piece_grid.y),
        .draw (draw[dx*4+dy]),
        .off  (off[dx*4+dy]),
        .cx   (cx[dx*4+dy]),
        .cy   (cy[dx*4+dy])
      );
    end
  end

  logic [BOARD_W-1:0][BOARD_H-1:0] hit;
  logic [NCELL-1:0]                land_on_full;
  game_state_t                     next_state;

  always_comb begin
    hit          = '0;
    land_on_full = '0;
    for (int c = 0; c < NCELL; c++) begin
      if (draw[c]) begin
        hit[cx[c]][cy[c]] = 1'b1;
        land_on_full[c]   = base_state.screen[cx[c]][cy[c]];
      end
    end
  end

  // non-screen fields ride through untouched; OR keeps filled base cells set
  always_comb begin
    next_state        = base_state;
    next_state.screen = base_state.screen | (no_piece ? '0 : hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_state <= '0;
    else       out_state <= next_state;
  end

`ifdef BLIT_COLLISION_EN
  logic collision_nxt;
  assign collision_nxt = ~no_piece & ((|off) | (|land_on_full));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) collision <= 1'b0;
    else       collision <= collision_nxt;
  end
`else
  // overlap detection only feeds the optional collision flag
  logic unused_coll;
  assign unused_coll = ^{off, land_on_full};
`endif

endmodule

// File: tb/tb_blit_piece_reg.sv
// Self-checking bench for blit_piece_reg: directed vector table, reset
// sequence and randomized traffic against a cell-by-cell reference model.
module tb_blit_piece_reg;
  import game_state_pkg::*;
  import tetris_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               no_piece;
  game_state_t        base_state;
  active_piece_grid_t active_piece_grid;
  game_state_t        out_state;
`ifdef BLIT_COLLISION_EN
  logic               collision;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  blit_piece_reg dut (
    .clk               (clk),
    .reset             (reset),
    .no_piece          (no_piece),
    .base_state        (base_state),
    .active_piece_grid (active_piece_grid),
    .out_state         (out_state)
`ifdef BLIT_COLLISION_EN
    ,
    .collision         (collision)
`endif
  );

  typedef struct {
    string              name;
    logic               np;
    game_state_t        base;
    active_piece_grid_t apg;
    game_state_t        exp;
    logic               exp_coll;
  } vec_t;

  task automatic check_state(input string name, input game_state_t exp, input logic exp_coll);
    n_total++;
    if (out_state === exp) n_pass++;
    else $display("FAIL %s out_state got=%h want=%h", name, out_state, exp);
`ifdef BLIT_COLLISION_EN
    n_total++;
    if (collision === exp_coll) n_pass++;
    else $display("FAIL %s collision got=%b want=%b", name, collision, exp_coll);
`else
    if (exp_coll === 1'bx) $display("note: %s has undefined collision expectation", name);
`endif
  endtask

  // Reference: walk every occupied window cell with plain integer coordinates.
  function automatic void model(input logic np, input game_state_t b,
                                input active_piece_grid_t a,
                                output game_state_t r, output logic col);
    r   = b;
    col = 1'b0;
    if (!np) begin
      for (int dx = 0; dx < 4; dx++)
        for (int dy = 0; dy < 4; dy++)
          if (a.piece[dx][dy]) begin
            int bx = int'(a.x) + dx - 4;
            int by = int'(a.y) + dy - 4;
            if (bx >= 0 && bx < 10 && by >= 0 && by < 20) begin
              if (b.screen[bx][by]) col = 1'b1;
              r.screen[bx][by] = 1'b1;
            end else begin
              col = 1'b1;
            end
          end
    end
  endfunction

  function automatic active_piece_grid_t block2x2(input logic [4:0] x, input logic [4:0] y);
    active_piece_grid_t a = '0;
    a.x = x; a.y = y;
    a.piece[1][1] = 1'b1; a.piece[1][2] = 1'b1;
    a.piece[2][1] = 1'b1; a.piece[2][2] = 1'b1;
    return a;
  endfunction

  vec_t vecs[7];
  game_state_t        row0, empty, b33, e;
  active_piece_grid_t a;

  initial begin
    // ---- directed table (expected values written by hand) ----
    empty = '0;
    row0  = '0;
    for (int i = 0; i < 10; i++) row0.screen[i][0] = 1'b1;
    row0.score = 16'h1234; row0.level = 4'd7; row0.game_over = 1'b1;

    // gating: no_piece leaves the base untouched
    vecs[0] = '{"gate", 1'b1, row0, block2x2(5'd6, 5'd6), row0, 1'b0};

    e = '0; e.score = 16'hBEEF;
    e.screen[3][3] = 1; e.screen[3][4] = 1; e.screen[4][3] = 1; e.screen[4][4] = 1;
    empty.score = 16'hBEEF;
    vecs[1] = '{"blk_empty", 1'b0, empty, block2x2(5'd6, 5'd6), e, 1'b0};

    e = row0;
    e.screen[3][3] = 1; e.screen[3][4] = 1; e.screen[4][3] = 1; e.screen[4][4] = 1;
    vecs[2] = '{"blk_row0", 1'b0, row0, block2x2(5'd6, 5'd6), e, 1'b0};

    // clipping at the low corner: (-2,-2) dropped, (1,1) drawn
    a = '0; a.x = 5'd2; a.y = 5'd2; a.piece[0][0] = 1; a.piece[3][3] = 1;
    e = '0; e.screen[1][1] = 1;
    vecs[3] = '{"clip_low", 1'b0, '0, a, e, 1'b1};

    // overlap with a filled cell stays 1 and flags collision
    b33 = '0; b33.screen[3][3] = 1;
    e = b33; e.screen[3][4] = 1; e.screen[4][3] = 1; e.screen[4][4] = 1;
    vecs[4] = '{"overlap", 1'b0, b33, block2x2(5'd6, 5'd6), e, 1'b1};

    // same piece moved to a free in-bounds spot: cells (1..2,1..2)
    e = b33; e.screen[1][1] = 1; e.screen[1][2] = 1; e.screen[2][1] = 1; e.screen[2][2] = 1;
    vecs[5] = '{"free_move", 1'b0, b33, block2x2(5'd4, 5'd4), e, 1'b0};

    // clipping at the high corner: (9,19) drawn, (12,22) dropped, no wrap
    a = '0; a.x = 5'd13; a.y = 5'd23; a.piece[0][0] = 1; a.piece[3][3] = 1;
    e = '0; e.screen[9][19] = 1;
    vecs[6] = '{"clip_high", 1'b0, '0, a, e, 1'b1};

    // ---- reset with arbitrary inputs ----
    reset = 1'b1; no_piece = 1'b0;
    base_state = row0; active_piece_grid = block2x2(5'd6, 5'd6);
    #1 check_state("reset_async", '0, 1'b0);
    @(posedge clk); #1 check_state("reset_held", '0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1 check_state("reset_release", vecs[2].exp, vecs[2].exp_coll);

    // ---- table, one vector per cycle ----
    foreach (vecs[k]) begin
      no_piece = vecs[k].np; base_state = vecs[k].base; active_piece_grid = vecs[k].apg;
      @(posedge clk); #1 check_state(vecs[k].name, vecs[k].exp, vecs[k].exp_coll);
    end

    // ---- randomized traffic ----
    for (int n = 0; n < 300; n++) begin
      game_state_t r; logic rc;
      for (int i = 0; i < 10; i++) base_state.screen[i] = 20'($urandom) & 20'($urandom);
      base_state.score     = 16'($urandom);
      base_state.level     = 4'($urandom);
      base_state.game_over = 1'($urandom);
      active_piece_grid.piece = 16'($urandom);
      active_piece_grid.x     = 5'($urandom_range(0, 31));
      active_piece_grid.y     = 5'($urandom_range(0, 31));
      no_piece = ($urandom_range(0, 7) == 0);
      model(no_piece, base_state, active_piece_grid, r, rc);
      @(posedge clk); #1 check_state("random", r, rc);
    end

    // ---- async reset mid-cycle with a nonzero output ----
    no_piece = vecs[1].np; base_state = vecs[1].base; active_piece_grid = vecs[1].apg;
    @(posedge clk); #1 check_state("pre_reset", vecs[1].exp, vecs[1].exp_coll);
    #2 reset = 1'b1;
    #1 check_state("reset_mid_async", '0, 1'b0);
    @(posedge clk); #1 check_state("reset_mid_held", '0, 1'b0);
    reset = 1'b0;
    no_piece = vecs[4].np; base_state = vecs[4].base; active_piece_grid = vecs[4].apg;
    @(posedge clk); #1 check_state("reset_mid_release", vecs[4].exp, vecs[4].exp_coll);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
